// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared across the 16-bit RISC CPU.
//   - default address/data widths and the reset PC
//   - fetch FSM state encoding
//   - opcode constants and extraction helper for the downstream decoder
package cpu_pkg;

  localparam int ADDR_W_DEF   = 8;
  localparam int DATA_W_DEF   = 16;
  localparam int RESET_PC_DEF = 0;

  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } fetch_state_t;

  // Major opcode lives in the top two bits of the instruction word.
  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_ALU = 2'b01,
    OP_STR = 2'b10,
    OP_LDR = 2'b11
  } opcode_t;

  function automatic opcode_t opcode_of(input logic [DATA_W_DEF-1:0] instr);
    return opcode_t'(instr[DATA_W_DEF-1 -: 2]);
  endfunction

endpackage

// File: rtl/pc_register.sv
// pc_register: program counter with asynchronous active-low reset.
// Ports:
//   clk    in          clock
//   reset  in          asynchronous reset, active low
//   inc    in          advance pc by one (wraps modulo 2^ADDR_W)
//   load   in          load pc from target; wins over inc
//   target in  ADDR_W  load value
//   pc     out ADDR_W  current program counter
module pc_register
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg <= RESET_PC;
    end else if (load) begin
      pc_reg <= target;
    end else if (inc) begin
      pc_reg <= pc_reg + ADDR_W'(1);
    end
  end

  assign pc = pc_reg;

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage.
// Presents pc to the shared synchronous-read RAM while granted, captures the
// returned word into the instruction register and offers it to the controller
// with a valid/ready handshake. A redirect reloads pc and flushes the fetch.
// Ports:
//   clk          in          clock
//   reset        in          asynchronous reset, active low
//   mem_gnt      in          RAM read port granted to fetch (sampled in ISSUE)
//   mem_addr     out ADDR_W  RAM read address, always equal to pc
//   mdata        in  DATA_W  RAM read data, one cycle after address
//   redirect     in          load pc from target, flush fetch
//   target       in  ADDR_W  redirect address
//   instruction  out DATA_W  instruction register
//   instr_valid  out         instruction holds an unconsumed word
//   instr_ready  in          controller accepts instruction
//   instr_pc     out ADDR_W  address instruction was fetched from
//   pc           out ADDR_W  address of the next fetch
//   fetch_count  out 16      accepted instructions, saturating
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                DATA_W   = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] target,
  output logic [DATA_W-1:0] instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [15:0]       fetch_count
);

  fetch_state_t      state_reg, state_next;
  logic              pc_inc;
  logic              ir_load;
  logic              count_inc;
  logic [DATA_W-1:0] instruction_reg;
  logic [ADDR_W-1:0] instr_pc_reg;
  logic              instr_valid_reg;
  logic [15:0]       fetch_count_reg;

  pc_register #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk   (clk),
    .reset (reset),
    .inc   (pc_inc),
    .load  (redirect),
    .target(target),
    .pc    (pc)
  );

  always_comb begin
    state_next = state_reg;
    pc_inc     = 1'b0;
    ir_load    = 1'b0;
    count_inc  = 1'b0;
    case (state_reg)
      ISSUE: begin
        if (mem_gnt) state_next = CAPTURE;
      end
      CAPTURE: begin
        // Grant is not re-checked: the read is already in the RAM pipeline.
        ir_load    = 1'b1;
        pc_inc     = 1'b1;
        state_next = HOLD;
      end
      HOLD: begin
        if (instr_ready) begin
          count_inc  = 1'b1;
          state_next = ISSUE;
        end
      end
      default: state_next = ISSUE;
    endcase
    // Redirect overrides everything except a handshake completing in HOLD,
    // which is still counted. The pc load itself wins inside pc_register.
    if (redirect) begin
      state_next = ISSUE;
      ir_load    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ISSUE;
      instruction_reg <= '0;
      instr_pc_reg    <= RESET_PC;
      instr_valid_reg <= 1'b0;
      fetch_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      // Registered valid: asserted exactly while the FSM sits in HOLD.
      instr_valid_reg <= (state_next == HOLD);
      if (ir_load) begin
        instruction_reg <= mdata;
        instr_pc_reg    <= pc;
      end
      if (count_inc && (fetch_count_reg != 16'hFFFF)) begin
        fetch_count_reg <= fetch_count_reg + 16'd1;
      end
    end
  end

  assign mem_addr    = pc;
  assign instruction = instruction_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = instr_valid_reg;
  assign fetch_count = fetch_count_reg;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 16-bit RISC CPU. It holds the program counter, drives the read address of the shared 256×16 synchronous-read RAM while the controller grants memory to fetch, and captures each returned word into the instruction register. The instruction is then handed to the decoder/controller FSM with a valid/ready handshake. Branch and redirect requests from the controller reload the PC and discard any fetch in flight.

## Interface
- `ADDR_W`, 8, PC and RAM address width.
- `DATA_W`, 16, instruction and RAM word width.
- `RESET_PC`, 8'h00, PC value loaded on reset.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `mem_gnt`  in  1  controller grants the RAM read port to fetch this cycle.
- `mem_addr`  out  ADDR_W  RAM read address; equals `pc` at all times.
- `mdata`  in  DATA_W  RAM read data, valid one cycle after its address is presented.
- `redirect`  in  1  load `pc` from `target`; flush the fetch.
- `target`  in  ADDR_W  redirect address.
- `instruction`  out  DATA_W  instruction register contents.
- `instr_valid`  out  1  `instruction` holds an unconsumed word.
- `instr_ready`  in  1  controller accepts `instruction` this cycle.
- `instr_pc`  out  ADDR_W  address `instruction` was fetched from.
- `pc`  out  ADDR_W  address of the next fetch.
- `fetch_count`  out  16  instructions accepted since reset; saturating.

## Operation
- The FSM has three states.
  - `ISSUE`: `mem_addr`=`pc`. If `mem_gnt`=1, go to `CAPTURE`; otherwise stay in `ISSUE` (stall).
  - `CAPTURE`: `instruction`<=`mdata`, `instr_pc`<=`pc`, `pc`<=`pc`+1, go to `HOLD`.
  - `HOLD`: `instr_valid`=1. On `instr_ready`=1, `fetch_count`++ and go to `ISSUE`; otherwise stay, with all outputs stable.
- `instr_valid` is a registered output. It is 1 only in `HOLD` and must not drop until the word is accepted.
- PC increment is modulo 2^ADDR_W: 8'hFF wraps to 8'h00 with no flag.
- `fetch_count` saturates at 16'hFFFF.
- Redirect has the highest priority and applies in every state: `pc`<=`target`, next state is `ISSUE`, and `instr_valid` is 0 next cycle.
  - In `CAPTURE`, the returned word is discarded and the IR is not written.
  - In `HOLD` with `instr_ready`=1 in the same cycle, the handshake completes: `fetch_count` increments, then the redirect applies.
  - In `HOLD` with `instr_ready`=0, the held word is dropped and not counted.
- `mem_gnt` is sampled only in `ISSUE`. A loss of grant during `CAPTURE` does not affect the capture, because the read is already in the RAM pipeline.
- Reset values (asynchronous, while `reset`=0):
  - state=`ISSUE`, `pc`=`RESET_PC`
  - `instruction`=16'h0000, `instr_pc`=`RESET_PC`, `instr_valid`=0
  - `fetch_count`=0
- Reset mid-operation abandons any in-flight read.

## Timing
- Latency: `reset` released before edge 0 with `mem_gnt`=1 gives `ISSUE` at cycle 0, `CAPTURE` at cycle 1, and `instr_valid`=1 in cycle 2.
- Throughput with continuous grant and ready is 1 instruction per 3 cycles.
- Redirect asserted in cycle n puts `mem_addr`=`target` in cycle n+1, with the first valid instruction in cycle n+3.
- Each cycle of `mem_gnt`=0 in `ISSUE` adds exactly one cycle.
- `mem_addr`, `pc`, `instruction`, `instr_pc`, `instr_valid` and `fetch_count` are all register outputs with no combinational path from inputs.

## Structure
- Shared package `cpu_pkg`:
  - fetch state enum {`ISSUE`, `CAPTURE`, `HOLD`}
  - `ADDR_W`/`DATA_W` defaults and `RESET_PC`
  - opcode constants (MOV, ALU, STR, LDR) for use by the downstream decoder
- Sub-module `pc_register`: ADDR_W register with asynchronous active-low reset to `RESET_PC`. It takes increment and load/target inputs, and load wins over increment.
- The FSM, IR, `instr_pc` and `fetch_count` stay in the top level.

## Test plan
- Reset then run: RAM[0..2]=16'hD105, 16'hD20A, 16'hA043, with grant and ready held at 1. Expect `instr_valid` in cycles 2, 5 and 8 with those words, `instr_pc`=0, 1, 2, and `fetch_count`=3 after cycle 8.
- Backpressure: `instr_ready`=0 for 5 cycles in `HOLD`. `instruction` and `instr_valid` must be stable, `pc` must not move, and `fetch_count` must not change.
- Grant stall: `mem_gnt`=0 for 4 cycles in `ISSUE`. The first valid must be delayed by exactly 4 cycles and `mem_addr` held.
- Redirect in `CAPTURE` with `target`=8'h40. The captured word must be discarded, `mem_addr`=8'h40 the next cycle, and the next instruction must be RAM[0x40] with `instr_pc`=8'h40.
- Redirect together with `instr_ready` in `HOLD`. `fetch_count` must increment and the fetch must resume at `target`.
- Wrap and reset: `pc` at 8'hFF fetches then moves to 8'h00. `reset`=0 asserted asynchronously mid-`CAPTURE` must zero the outputs immediately and leave the IR unwritten.
